// File: rtl/dpram_lsu_pkg.sv
// Shared encodings for the port-B load/store unit: access sizes,
// FSM states and the per-size byte masks used to build write strobes.
package dpram_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_X = 2'd3;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC0,
        ST_ACC1,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Right-justified byte mask of an access size (illegal size gives no bytes)
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_B:    size_mask = MASK_B;
            SZ_H:    size_mask = MASK_H;
            SZ_W:    size_mask = MASK_W;
            default: size_mask = 4'b0000;
        endcase
    endfunction

    // Number of bytes touched by an access size; illegal size is treated as a word
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    size_bytes = 3'd1;
            SZ_H:    size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dpram_lsu_align.sv
// Combinational data steering for the load/store unit: places store data
// and strobes across a two-word window, and pulls load data back out of it
// with sign or zero extension.
module dpram_lsu_align
    import dpram_lsu_pkg::*;
(
    input  logic [1:0]  st_off,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_wdata,
    output logic [63:0] st_data,
    output logic [7:0]  st_mask,
    input  logic [1:0]  ld_off,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic [31:0] word0,
    input  logic [31:0] word1,
    output logic [31:0] ld_data
);

    logic [63:0] ld_window;

    // Shift store data/mask up by the byte offset; shift the load window down by it
    always_comb begin
        st_data   = {32'b0, st_wdata} << {st_off, 3'b000};
        st_mask   = {4'b0000, size_mask(st_size)} << st_off;
        ld_window = {word1, word0} >> {ld_off, 3'b000};
        case (ld_size)
            SZ_B:    ld_data = ld_unsigned ? {24'b0, ld_window[7:0]}
                                           : {{24{ld_window[7]}}, ld_window[7:0]};
            SZ_H:    ld_data = ld_unsigned ? {16'b0, ld_window[15:0]}
                                           : {{16{ld_window[15]}}, ld_window[15:0]};
            default: ld_data = ld_window[31:0];
        endcase
    end

endmodule

// File: rtl/dpram_lsu_port.sv
// Port-B initiator of the dual-port data RAM. Turns byte-addressed
// loads/stores into one or two word accesses with byte strobes and returns
// a single-cycle response carrying aligned, extended load data or a fault.
module dpram_lsu_port
    import dpram_lsu_pkg::*;
#(
    parameter  int RAM_DEPTH = 2048,
    localparam int AW        = $clog2(RAM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] ram_addrb,
    output logic [31:0]   ram_dinb,
    output logic          ram_web,
    output logic [3:0]    ram_wemb,
    output logic          ram_enb,
    input  logic [31:0]   ram_doutb
);

    state_t        state;
    logic [1:0]    off;
    logic [AW-1:0] w0;
    logic          split;
    logic          fault;
    logic [63:0]   st_data;
    logic [7:0]    st_mask;
    logic [31:0]   ld_data;

    logic          r_we;
    logic [1:0]    r_size;
    logic          r_unsigned;
    logic [1:0]    r_off;
    logic          r_split;
    logic [AW-1:0] r_w1;
    logic [31:0]   hi_data;
    logic [3:0]    hi_mask;
    logic [31:0]   word0_q;
    logic          enb_q;
    logic          web_q;

    // Decode the incoming request: offset, first word, split and fault detection
    always_comb begin
        off   = req_addr[1:0];
        w0    = req_addr[AW+1:2];
        split = ({2'b00, off} + {1'b0, size_bytes(req_size)}) > 4'd4;
        fault = (req_size == SZ_X)
             || ({2'b00, req_addr[31:2]} >= 32'(RAM_DEPTH))
             || (split && (w0 == AW'(RAM_DEPTH - 1)));
    end

    dpram_lsu_align u_align (
        .st_off      (off),
        .st_size     (req_size),
        .st_wdata    (req_wdata),
        .st_data     (st_data),
        .st_mask     (st_mask),
        .ld_off      (r_off),
        .ld_size     (r_size),
        .ld_unsigned (r_unsigned),
        .word0       (r_split ? word0_q : ram_doutb),
        .word1       (ram_doutb),
        .ld_data     (ld_data)
    );

    // Reset kills the enable/write strobes immediately so an interrupted access never lands
    assign ram_enb = enb_q & ~rst;
    assign ram_web = web_q & ~rst;

    // Request FSM with registered RAM and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            ram_addrb  <= '0;
            ram_dinb   <= '0;
            ram_wemb   <= '0;
            enb_q      <= 1'b0;
            web_q      <= 1'b0;
            r_we       <= 1'b0;
            r_size     <= SZ_B;
            r_unsigned <= 1'b0;
            r_off      <= '0;
            r_split    <= 1'b0;
            r_w1       <= '0;
            hi_data    <= '0;
            hi_mask    <= '0;
            word0_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready  <= 1'b0;
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_off      <= off;
                        r_split    <= split;
                        r_w1       <= w0 + AW'(1);
                        hi_data    <= st_data[63:32];
                        hi_mask    <= st_mask[7:4];
                        if (fault) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state     <= ST_ACC0;
                            enb_q     <= 1'b1;
                            web_q     <= req_we;
                            ram_addrb <= w0;
                            ram_dinb  <= st_data[31:0];
                            ram_wemb  <= req_we ? st_mask[3:0] : 4'b0000;
                        end
                    end
                end
                ST_ACC0: begin
                    if (r_split) begin
                        state     <= ST_ACC1;
                        ram_addrb <= r_w1;
                        ram_dinb  <= hi_data;
                        ram_wemb  <= r_we ? hi_mask : 4'b0000;
                    end else begin
                        enb_q    <= 1'b0;
                        web_q    <= 1'b0;
                        ram_wemb <= 4'b0000;
                        if (r_we) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_ACC1: begin
                    word0_q  <= ram_doutb;
                    enb_q    <= 1'b0;
                    web_q    <= 1'b0;
                    ram_wemb <= 4'b0000;
                    if (r_we) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    state     <= ST_RESP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= ld_data;
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dpram_lsu_port.sv
// Self-checking bench for dpram_lsu_port: a behavioural RAM model on port B,
// a response scoreboard checking data, fault flag and latency, a vector
// table of loads/stores, and hand sequences for split, fault, back-to-back
// and reset-in-flight cases.
module tb_dpram_lsu_port;

    localparam int RAM_DEPTH = 2048;
    localparam int AW        = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] ram_addrb;
    logic [31:0]   ram_dinb;
    logic          ram_web;
    logic [3:0]    ram_wemb;
    logic          ram_enb;
    logic [31:0]   ram_doutb;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    logic [31:0] mem [0:RAM_DEPTH-1];
    exp_t        exp_q[$];
    int          acc_q[$];
    int          acc_log[$];
    vec_t        vecs[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          enb_seen;

    dpram_lsu_port #(.RAM_DEPTH(RAM_DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_addrb    (ram_addrb),
        .ram_dinb     (ram_dinb),
        .ram_web      (ram_web),
        .ram_wemb     (ram_wemb),
        .ram_enb      (ram_enb),
        .ram_doutb    (ram_doutb)
    );

    always #5 clk = ~clk;

    function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic err, input int lat);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.rdata = rdata; v.err = err; v.lat = lat;
        return v;
    endfunction

    // Behavioural port-B RAM: byte-strobed write, read-first registered read
    always @(posedge clk) begin
        if (ram_enb) begin
            for (int b = 0; b < 4; b++)
                if (ram_web && ram_wemb[b])
                    mem[ram_addrb][b*8 +: 8] <= ram_dinb[b*8 +: 8];
            ram_doutb <= mem[ram_addrb];
        end
    end

    // Log accept cycles; a reset discards any in-flight request
    always @(posedge clk) begin
        if (rst) begin
            acc_q.delete();
        end else if (req_valid && req_ready) begin
            acc_q.push_back(cyc);
            acc_log.push_back(cyc);
        end
        cyc++;
    end

    // Scoreboard: compare every response against the oldest expectation
    always @(negedge clk) begin
        if (ram_enb) enb_seen = 1'b1;
        if (!rst && rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL unexpected_rsp: got rsp_valid=1, expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                int   a;
                e = exp_q.pop_front();
                a = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
                checkOutput("rsp_rdata", rsp_rdata, e.rdata);
                checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                checkOutput("latency", 32'(cyc - a), 32'(e.lat));
            end
        end
    end

    // Issue one request; returns at the negedge of the cycle after acceptance
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input logic err, input int lat,
                                 input bit expect_rsp);
        int g;
        exp_t e;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        e.rdata = rdata; e.err = err; e.lat = lat;
        if (expect_rsp) exp_q.push_back(e);
        g = 0;
        while (!req_ready && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (g >= 40) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || !req_ready) && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (g >= 40) checkOutput("rsp_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < RAM_DEPTH; i++) mem[i] = 32'h0;
        ram_doutb    = 32'h0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        repeat (3) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("reset_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset_ram_enb", {31'b0, ram_enb}, 32'd0);
        checkOutput("reset_ram_web", {31'b0, ram_web}, 32'd0);
        checkOutput("reset_ram_wemb", {28'b0, ram_wemb}, 32'd0);
        checkOutput("reset_ram_addrb", {21'b0, ram_addrb}, 32'd0);
        checkOutput("reset_ram_dinb", ram_dinb, 32'd0);
        rst = 1'b0;

        $display("[TB] aligned SW 0x10");
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1);
        checkOutput("sw_addrb", {21'b0, ram_addrb}, 32'd4);
        checkOutput("sw_wemb", {28'b0, ram_wemb}, 32'hF);
        checkOutput("sw_dinb", ram_dinb, 32'hDEADBEEF);
        checkOutput("sw_web", {31'b0, ram_web}, 32'd1);
        checkOutput("sw_enb", {31'b0, ram_enb}, 32'd1);
        waitIdle();

        vecs.push_back(mk(0, 2'd0, 0, 32'h13,   32'h0,        32'hFFFFFFDE, 0, 3));
        vecs.push_back(mk(0, 2'd0, 1, 32'h13,   32'h0,        32'h000000DE, 0, 3));
        vecs.push_back(mk(0, 2'd1, 1, 32'h12,   32'h0,        32'h0000DEAD, 0, 3));
        vecs.push_back(mk(0, 2'd1, 0, 32'h10,   32'h0,        32'hFFFFBEEF, 0, 3));
        vecs.push_back(mk(0, 2'd2, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0, 3));
        vecs.push_back(mk(1, 2'd0, 0, 32'h21,   32'hFFFFFFAB, 32'h0,        0, 2));
        vecs.push_back(mk(0, 2'd2, 0, 32'h20,   32'h0,        32'h0000AB00, 0, 3));
        vecs.push_back(mk(1, 2'd1, 0, 32'h26,   32'h12348001, 32'h0,        0, 2));
        vecs.push_back(mk(0, 2'd2, 0, 32'h24,   32'h0,        32'h80010000, 0, 3));
        vecs.push_back(mk(0, 2'd1, 0, 32'h26,   32'h0,        32'hFFFF8001, 0, 3));
        vecs.push_back(mk(0, 2'd0, 0, 32'h21,   32'h0,        32'hFFFFFFAB, 0, 3));
        vecs.push_back(mk(1, 2'd1, 0, 32'h23,   32'h00005566, 32'h0,        0, 3));
        vecs.push_back(mk(0, 2'd1, 1, 32'h23,   32'h0,        32'h00005566, 0, 4));
        vecs.push_back(mk(0, 2'd2, 0, 32'h20,   32'h0,        32'h6600AB00, 0, 3));
        vecs.push_back(mk(0, 2'd2, 0, 32'h24,   32'h0,        32'h80010055, 0, 3));
        vecs.push_back(mk(0, 2'd2, 0, 32'h22,   32'h0,        32'h00556600, 0, 4));
        vecs.push_back(mk(0, 2'd1, 0, 32'h1FFF, 32'h0,        32'h0,        1, 1));
        vecs.push_back(mk(0, 2'd3, 0, 32'h0,    32'h0,        32'h0,        1, 1));
        vecs.push_back(mk(1, 2'd2, 0, 32'h3FFC, 32'h1,        32'h0,        1, 1));
        vecs.push_back(mk(0, 2'd2, 0, 32'h1FFC, 32'h0,        32'h0,        0, 3));
        vecs.push_back(mk(0, 2'd0, 0, 32'h1FFF, 32'h0,        32'h0,        0, 3));

        $display("[TB] vector table, %0d entries", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                          vecs[i].rdata, vecs[i].err, vecs[i].lat, 1'b1);
            waitIdle();
        end

        $display("[TB] out-of-range LW 0x2000");
        enb_seen = 1'b0;
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h2000, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        waitIdle();
        checkOutput("err_enb_seen", {31'b0, enb_seen}, 32'd0);

        $display("[TB] split SW 0x0E");
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h0E, 32'h11223344, 32'h0, 1'b0, 3, 1'b1);
        checkOutput("split_acc0_addrb", {21'b0, ram_addrb}, 32'd3);
        checkOutput("split_acc0_wemb", {28'b0, ram_wemb}, 32'hC);
        checkOutput("split_acc0_dinb", ram_dinb, 32'h33440000);
        @(negedge clk);
        checkOutput("split_acc1_addrb", {21'b0, ram_addrb}, 32'd4);
        checkOutput("split_acc1_wemb", {28'b0, ram_wemb}, 32'h3);
        checkOutput("split_acc1_dinb", ram_dinb, 32'h00001122);
        waitIdle();
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h0E, 32'h0, 32'h11223344, 1'b0, 4, 1'b1);
        waitIdle();
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEAD1122, 1'b0, 3, 1'b1);
        waitIdle();

        $display("[TB] back-to-back stores");
        acc_log.delete();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            int   g;
            exp_t e;
            req_valid    = 1'b1;
            req_we       = 1'b1;
            req_size     = 2'd2;
            req_unsigned = 1'b0;
            req_addr     = 32'h40 + 32'(k * 4);
            req_wdata    = 32'hA0000001 + 32'(k);
            e.rdata = 32'h0; e.err = 1'b0; e.lat = 2;
            exp_q.push_back(e);
            g = 0;
            while (!req_ready && g < 40) begin
                @(negedge clk);
                g++;
            end
            if (g >= 40) checkOutput("b2b_accept_timeout", 32'd0, 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        waitIdle();
        checkOutput("b2b_accept_count", 32'(acc_log.size()), 32'd3);
        if (acc_log.size() == 3) begin
            checkOutput("b2b_spacing_1", 32'(acc_log[1] - acc_log[0]), 32'd3);
            checkOutput("b2b_spacing_2", 32'(acc_log[2] - acc_log[1]), 32'd3);
        end
        checkOutput("b2b_word16", mem[16], 32'hA0000001);
        checkOutput("b2b_word17", mem[17], 32'hA0000002);
        checkOutput("b2b_word18", mem[18], 32'hA0000003);

        $display("[TB] reset during ACC1 of split SW 0x0E");
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h0E, 32'h55667788, 32'h0, 1'b0, 0, 1'b0);
        @(negedge clk);
        checkOutput("rst_acc1_addrb", {21'b0, ram_addrb}, 32'd4);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("rst_ram_web", {31'b0, ram_web}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_word3", mem[3], 32'h77880000);
        checkOutput("rst_word4", mem[4], 32'hDEAD1122);
        checkOutput("rst_no_pending", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
